// File: rtl/instr_feeder_if.sv
// Bus between the instruction feeder and its host/processor: loader strobes,
// run/done handshake and status outputs.
interface instr_feeder_if #(
  parameter int unsigned AW = 4
);
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [8:0]    prog_data;
  logic          done;
  logic [8:0]    din;
  logic          run;
  logic          busy;
  logic          halted;
  logic [AW-1:0] pc;
  logic          error;

  modport master (
    input  start, prog_we, prog_addr, prog_data, done,
    output din, run, busy, halted, pc, error
  );

  modport slave (
    output start, prog_we, prog_addr, prog_data, done,
    input  din, run, busy, halted, pc, error
  );
endinterface

// File: rtl/instr_feeder.sv
// Program sequencer driving a processor's din/run from a loadable 9-bit program memory.
// Optional done-watchdog compiled in with INSTR_FEEDER_WATCHDOG_EN.
module instr_feeder #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic            clk,
  input logic            resetn,
  instr_feeder_if.master bus
);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StImm, StWait, StHalt} state_e;

  localparam logic [2:0] OpMvi  = 3'b001;
  localparam logic [2:0] OpHalt = 3'b111;

  if (DEPTH != (1 << AW) || TIMEOUT == 0) begin : g_param_check
    $error("instr_feeder: DEPTH must equal 2**AW and TIMEOUT must be nonzero");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [8:0]    din_q, din_d;
  logic          halted_q, halted_d;
  logic [8:0]    mem_q [DEPTH];

  logic          busy, start_ok, timeout;
  logic [8:0]    cur_word, nxt_word;
  logic          is_mvi, is_halt;
  logic [AW:0]   pc_sum;

  assign busy     = state_q inside {StCheck, StIssue, StImm, StWait};
  assign start_ok = bus.start && (state_q == StIdle || state_q == StHalt);
  assign cur_word = mem_q[pc_q];
  assign nxt_word = mem_q[pc_q + AW'(1)];
  assign is_mvi   = cur_word[8:6] == OpMvi;
  assign is_halt  = cur_word[8:6] == OpHalt;
  // Extra top bit flags a pc that runs past the last word.
  assign pc_sum   = {1'b0, pc_q} + (is_mvi ? (AW+1)'(2) : (AW+1)'(1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    din_d    = 9'h000;
    halted_d = halted_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (bus.start) begin
          state_d  = StCheck;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end
      StCheck: begin
        if (is_halt || (is_mvi && pc_q == AW'(DEPTH - 1))) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else begin
          state_d = StIssue;
          din_d   = cur_word;
        end
      end
      StIssue: begin
        if (is_mvi) begin
          state_d = StImm;
          din_d   = nxt_word;
        end else begin
          state_d = StWait;
        end
      end
      StImm, StWait: begin
        din_d = din_q;
        if (bus.done) begin
          din_d   = 9'h000;
          pc_d    = pc_sum[AW-1:0];
          state_d = pc_sum[AW] ? StHalt : StCheck;
          if (pc_sum[AW]) halted_d = 1'b1;
        end else if (timeout) begin
          din_d    = 9'h000;
          state_d  = StHalt;
          halted_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      din_q    <= 9'h000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      din_q    <= din_d;
      halted_q <= halted_d;
    end
  end

  // Program memory is not reset; loads are only accepted while idle or halted.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

`ifdef INSTR_FEEDER_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           error_q, error_d;

  assign timeout = (state_q inside {StImm, StWait}) && !bus.done &&
                   (wd_q == WdW'(TIMEOUT - 1));

  always_comb begin
    wd_d    = wd_q;
    error_d = error_q;
    if (state_q == StIssue) begin
      wd_d = '0;
    end else if (state_q inside {StImm, StWait}) begin
      wd_d = wd_q + WdW'(1);
    end
    if (start_ok) begin
      error_d = 1'b0;
    end else if (timeout) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign bus.error = error_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign timeout         = 1'b0;
  assign bus.error       = 1'b0;
`endif

  assign bus.din    = din_q;
  assign bus.run    = state_q inside {StIssue, StImm, StWait};
  assign bus.busy   = busy;
  assign bus.halted = halted_q;
  assign bus.pc     = pc_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: a program-level trace model predicts every cycle
// from CHECK to HALT and also generates the done stimulus.
module tb_instr_feeder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 15;
`ifdef INSTR_FEEDER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  typedef struct packed {
    logic       done;
    logic [8:0] din;
    logic       run;
    logic       busy;
    logic       halted;
    logic       err;
    logic [3:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;
  instr_feeder_if #(.AW(4)) bus ();

  instr_feeder #(.DEPTH(DEPTH), .AW(4), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [8:0] mm [DEPTH];
  ent_t       trace [$];
  int         wq [$];
  ent_t       cur_exp;
  bit         cur_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      chk("din", int'(bus.din), int'(cur_exp.din));
      chk("run", int'(bus.run), int'(cur_exp.run));
      chk("busy", int'(bus.busy), int'(cur_exp.busy));
      chk("halted", int'(bus.halted), int'(cur_exp.halted));
      chk("error", int'(bus.error), int'(cur_exp.err));
      chk("pc", int'(bus.pc), int'(cur_exp.pc));
    end
  end

  function automatic ent_t mk(input logic d, input logic [8:0] di, input logic r,
                              input logic b, input logic h, input logic e, input int p);
    ent_t x;
    x.done = d; x.din = di; x.run = r; x.busy = b; x.halted = h; x.err = e;
    x.pc = 4'(p);
    return x;
  endfunction

  // Walks the program as the processor would see it, one entry per clock from CHECK on.
  function automatic void gen();
    int         pc;
    int         n;
    logic [8:0] w;
    logic [8:0] imm;
    logic [2:0] op;
    pc = 0;
    trace.delete();
    for (int guard = 0; guard < 64; guard++) begin
      w  = mm[pc];
      op = w[8:6];
      trace.push_back(mk(1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, pc));
      if (op == 3'b111 || (op == 3'b001 && pc == DEPTH - 1)) begin
        trace.push_back(mk(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, pc));
        return;
      end
      trace.push_back(mk(1'b0, w, 1'b1, 1'b1, 1'b0, 1'b0, pc));
      imm = (op == 3'b001) ? mm[(pc + 1) % DEPTH] : 9'h000;
      n   = (wq.size() > 0) ? wq.pop_front() : 0;
      if (WD && n >= TIMEOUT) begin
        repeat (TIMEOUT) trace.push_back(mk(1'b0, imm, 1'b1, 1'b1, 1'b0, 1'b0, pc));
        trace.push_back(mk(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, pc));
        return;
      end
      repeat (n) trace.push_back(mk(1'b0, imm, 1'b1, 1'b1, 1'b0, 1'b0, pc));
      trace.push_back(mk(1'b1, imm, 1'b1, 1'b1, 1'b0, 1'b0, pc));
      pc += (op == 3'b001) ? 2 : 1;
      if (pc >= DEPTH) begin
        trace.push_back(mk(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, pc % DEPTH));
        return;
      end
    end
  endfunction

  task automatic load(input int a, input logic [8:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = 4'(a); bus.prog_data = d; mm[a] = d;
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
  endtask

  task automatic start_prog(input bit we, input int a, input logic [8:0] d);
    bus.start = 1'b1;
    if (we) begin
      bus.prog_we = 1'b1; bus.prog_addr = 4'(a); bus.prog_data = d; mm[a] = d;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.prog_we = 1'b0;
  endtask

  // Replays the model trace; optionally hammers writes to [0] on every busy cycle.
  task automatic run_trace(input bit spam);
    for (int i = 0; i < trace.size(); i++) begin
      cur_exp  = trace[i];
      bus.done = trace[i].done;
      if (spam && trace[i].busy) begin
        bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = 9'h1FF;
      end else begin
        bus.prog_we = 1'b0;
      end
      cur_valid = 1'b1;
      @(posedge clk); #1;
    end
    cur_valid = 1'b0; bus.done = 1'b0; bus.prog_we = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.done = 1'b0;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;

    chk("rst_din", int'(bus.din), 0);
    chk("rst_run", int'(bus.run), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_error", int'(bus.error), 0);

    // mvi with immediate, then HALT
    load(0, 9'h040); load(1, 9'h05A); load(2, 9'h1C0);
    wq = '{2};
    gen();
    chk("model_issue_din", int'(trace[1].din), 'h040);
    chk("model_imm_din", int'(trace[2].din), 'h05A);
    chk("model_t1_len", trace.size(), 7);
    start_prog(1'b0, 0, 9'h000);
    run_trace(1'b0);
    chk("t1_pc", int'(bus.pc), 2);
    chk("t1_halted", int'(bus.halted), 1);
    chk("t1_run", int'(bus.run), 0);

    // add r1,r2 written together with start; three WAIT cycles before done
    load(1, 9'h1C0);
    start_prog(1'b1, 0, 9'h08A);
    wq = '{3};
    gen();
    chk("model_t2_len", trace.size(), 8);
    run_trace(1'b0);
    chk("t2_pc", int'(bus.pc), 1);
    chk("t2_halted", int'(bus.halted), 1);

    // writes while busy are dropped; second run shows [0] unchanged
    wq = '{1}; gen();
    start_prog(1'b0, 0, 9'h000);
    run_trace(1'b1);
    wq = '{0}; gen();
    start_prog(1'b0, 0, 9'h000);
    run_trace(1'b0);

    // reset during IMM, then rerun from scratch
    load(0, 9'h040); load(1, 9'h05A); load(2, 9'h1C0);
    start_prog(1'b0, 0, 9'h000);
    @(posedge clk); @(posedge clk); #1;
    chk("imm_run", int'(bus.run), 1);
    chk("imm_din", int'(bus.din), 'h05A);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_run", int'(bus.run), 0);
    chk("mid_rst_pc", int'(bus.pc), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_din", int'(bus.din), 0);
    resetn = 1'b0;
    wq = '{1}; gen();
    start_prog(1'b0, 0, 9'h000);
    run_trace(1'b0);

    // mvi at the last word: halts without being issued
    for (int i = 0; i < DEPTH - 1; i++) load(i, 9'h00A);
    load(DEPTH - 1, 9'h040);
    wq.delete(); gen();
    chk("model_t5_len", trace.size(), 47);
    start_prog(1'b0, 0, 9'h000);
    run_trace(1'b0);
    chk("t5_pc", int'(bus.pc), 15);
    chk("t5_halted", int'(bus.halted), 1);

    // non-mvi at the last word: pc wraps and the program halts
    load(DEPTH - 1, 9'h08A);
    wq.delete(); gen();
    start_prog(1'b0, 0, 9'h000);
    run_trace(1'b0);
    chk("t6_pc", int'(bus.pc), 0);
    chk("t6_halted", int'(bus.halted), 1);

`ifdef INSTR_FEEDER_WATCHDOG_EN
    load(0, 9'h08A); load(1, 9'h1C0);
    wq = '{100}; gen();
    chk("model_wd_len", trace.size(), 18);
    start_prog(1'b0, 0, 9'h000);
    run_trace(1'b0);
    chk("wd_error", int'(bus.error), 1);
    chk("wd_run", int'(bus.run), 0);
    wq = '{0}; gen();
    start_prog(1'b0, 0, 9'h000);
    run_trace(1'b0);
    chk("wd_cleared", int'(bus.error), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Program sequencer that drives the processor's instruction bus from the initiator side of the run/done protocol. It holds a small loadable program memory of 9-bit words and presents each instruction on `din` with `run` high. For `mvi` it presents the following immediate word, then waits for `done` before advancing. It sits between the board-level loader/switches and the processor core, replacing manual `din`/`run` stimulus.

## Interface
- `DEPTH`, 16: program memory words (power of two, ≥4)
- `AW`, 4: address width, log2(DEPTH)
- `TIMEOUT`, 15: max cycles to wait for `done` (used only with watchdog compiled in)
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  reset, synchronous, active-high (asserted = 1)
- `start`  in  1  pulse: begin execution at address 0
- `prog_we`  in  1  program memory write strobe
- `prog_addr`  in  AW  write address
- `prog_data`  in  9  write data
- `done`  in  1  instruction-complete from processor control
- `din`  out  9  instruction/immediate bus to processor
- `run`  out  1  processor run enable
- `busy`  out  1  sequencer executing
- `halted`  out  1  program ended
- `pc`  out  AW  address of current instruction
- `error`  out  1  watchdog expired (sticky until reset/start)

## Operation
- Reset values: `din`=0, `run`=0, `busy`=0, `halted`=0, `pc`=0, `error`=0, state IDLE. Memory contents are not reset.
- Opcode = word[8:6]: 000 mv, 001 mvi, 010 add, 011 sub, 111 HALT. Any other opcode is issued like a non-mvi instruction.
- States:
  - IDLE: `run`=0, `din`=0. When `start`=1, set `pc`=0 and `error`=0, then go to CHECK.
  - CHECK: decide the word at `pc`. Halt if opcode=111, or if opcode=001 and `pc`=DEPTH-1 (no immediate available); the halt path sets `halted`=1 and goes to HALT. Otherwise go to ISSUE. `run`=0.
  - ISSUE: exactly 1 cycle. `din`=mem[pc], `run`=1. `done` is ignored. Next state is IMM if opcode=001, else WAIT.
  - IMM: `din`=mem[pc+1], `run`=1. Hold until `done` is sampled high.
  - WAIT: `din`=0, `run`=1. Hold until `done` is sampled high.
  - On `done` in IMM/WAIT: `pc` += 2 (mvi) or 1 (others).
    - If the new `pc` wraps past DEPTH-1: go to HALT, `halted`=1.
    - Otherwise go to CHECK.
  - HALT: `run`=0, `din`=0, `busy`=0. `start` restarts as from IDLE and clears `halted`.
- `busy`=1 in CHECK, ISSUE, IMM, WAIT.
- Memory write: when `prog_we`=1 and `busy`=0, mem[prog_addr] ← prog_data. Writes while `busy`=1 are dropped.
- `start` while `busy`=1 is ignored.
- `pc` arithmetic is AW bits. Wrap detection uses an AW+1-bit sum.

## Timing
- Memory read is combinational from `pc`. `din` is registered, valid on the same edge `run` rises.
- ISSUE aligns with processor counter state 00: IR latches on the ISSUE edge.
- IMM aligns with counter state 01: the immediate is on `din` while the processor selects `din`.
- Instruction-to-instruction: `done` edge → CHECK (1 cycle, `run`=0) → ISSUE. The processor counter therefore restarts at 00 with `run` low for one cycle.
- Latency `start` → first `run`: 2 cycles (CHECK, ISSUE).
- `resetn` mid-instruction: next edge forces reset values. `run` drops immediately; the processor is expected to be reset in parallel.
- Simultaneous `prog_we` and `start` in IDLE: the write completes and execution starts. CHECK reads the new contents.

## Configuration
- `INSTR_FEEDER_WATCHDOG_EN` defined:
  - A cycle counter runs in IMM/WAIT and clears on entry to ISSUE.
  - If it reaches `TIMEOUT` without `done`: `error`=1, `halted`=1, `run`=0, go to HALT.
  - `error` clears on `start` or reset.
- Not defined: no counter is built, `error` is tied 0, and IMM/WAIT wait indefinitely.

## Test plan
- Load [0]=001_000_000, [1]=0x05A, [2]=111_000_000, pulse `start`:
  - ISSUE `din`=0x040, IMM `din`=0x05A.
  - After `done`, `pc`=2, then `halted`=1 with `run`=0.
- Load add r1,r2 (010_001_010) at [0], HALT at [1]:
  - `run` stays high from ISSUE through 3 WAIT cycles until `done`.
  - Then `pc`=1, `halted`=1.
- `prog_we` to [0] with 0x1FF while `busy`=1 → memory unchanged; verify by rerunning after halt.
- Assert `resetn` during IMM → next cycle `run`=0, `pc`=0, `busy`=0. Pulse `start` afterwards: `din` returns to the same opcode word.
- mvi at [DEPTH-1] reached by sequential mv instructions → `halted`=1, no ISSUE cycle for that word.
- Watchdog on, `done` held 0 → `error`=1 and `run`=0 after exactly TIMEOUT=15 WAIT cycles. `start` clears `error`.
